rr_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer. Successor to the team's 4:1 single-bit mux.
- Each input channel uses a valid/ready handshake.
- Selects one channel per cycle, either by an external select (fixed mode) or by round-robin arbitration.
- Registers the chosen word into a single-entry output stage. Used wherever several producers share one consumer.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rr_mux.sv | 119 +++++++++++
 tb/tb_rr_mux.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared constants and helpers for the rr_mux channel multiplexer
// Rev 1.0
// ============================================================================
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of channels a select field of the given width can address.
    function automatic int max_channels(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, first request at or after ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_any
);

    localparam logic [SEL_W:0] c_n_ch = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0]  req_rot;
    logic [SEL_W-1:0] offset;
    logic [SEL_W:0]   idx_sum;

    always_comb begin
        // Doubling the request vector lets a plain shift rotate ptr to bit 0.
        req_rot   = N_CH'({req, req} >> ptr);
        offset    = '0;
        grant_any = 1'b0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset    = SEL_W'(j);
                grant_any = 1'b1;
            end
        end
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= c_n_ch) begin
            idx_sum = idx_sum - c_n_ch;
        end
        grant_idx = idx_sum[SEL_W-1:0];
        grant     = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
// rr_mux : N-channel valid/ready multiplexer, fixed-select or round-robin,
//          with a single-entry registered output stage
// Rev 1.0
// ============================================================================
module rr_mux
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0] c_n_ch = (SEL_W+1)'(N_CH);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic             sel_in_range;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             load;
    logic             accept;

    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_unpack
            assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end

        // Only a non-power-of-2 channel count leaves select codes unmapped.
        if (max_channels(SEL_W) == N_CH) begin : g_sel_full
            assign sel_in_range = 1'b1;
        end else begin : g_sel_partial
            assign sel_in_range = ({1'b0, sel} < c_n_ch);
        end
    endgenerate

    always_comb begin
        req = '0;
        if (mode == MODE_RR) begin
            req = in_valid;
        end else if (sel_in_range) begin
            req[sel] = 1'b1;
        end
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign load     = ~out_valid_q | out_ready;
    assign in_ready = grant & {N_CH{load & rst_n}};
    assign accept   = grant_any & |(in_valid & in_ready);

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_idx];
            out_ch_d    = grant_idx;
            if (mode == MODE_RR) begin
                if (({1'b0, grant_idx} + (SEL_W+1)'(1)) == c_n_ch) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + SEL_W'(1);
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux.sv
`default_nettype none
// ============================================================================
// tb_rr_mux : scoreboard bench for rr_mux (N_CH=4 and N_CH=3 instances)
// Rev 1.0
// ============================================================================
module tb_rr_mux;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [3:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic [7:0]  out_data;

    logic        mode_3, out_ready_3, out_valid_3;
    logic [1:0]  sel_3, out_ch_3;
    logic [2:0]  in_valid_3, in_ready_3;
    logic [23:0] in_data_3;
    logic [7:0]  out_data_3;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [3:0] t4_valid [6] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0100, 4'b0010};
    logic [3:0] t4_ready [6] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
    logic [1:0] t4_ch    [6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1};

    always #5 clk = ~clk;

    rr_mux #(.N_CH(4), .WIDTH(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_mux #(.N_CH(3), .WIDTH(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode_3), .sel(sel_3),
        .in_valid(in_valid_3), .in_data(in_data_3), .in_ready(in_ready_3),
        .out_valid(out_valid_3), .out_data(out_data_3), .out_ch(out_ch_3),
        .out_ready(out_ready_3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel k carries 0x11*(k+1) on both instances.
    function automatic exp_t mk(input logic [1:0] ch);
        exp_t e;
        e.ch   = ch;
        e.data = {2'b00, ch, 2'b00, ch} + 8'h11;
        return e;
    endfunction

    task automatic drain(input string name, input int which);
        int n = 0;
        while (((which == 4) ? q4.size() : q3.size()) != 0 && n < 20) begin
            step();
            n++;
        end
        chk(name, (which == 4) ? q4.size() : q3.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL dut4_unexpected_word: got ch %0d data 0x%0h, expected none", out_ch, out_data);
            end else begin
                e4 = q4.pop_front();
                chk("dut4_out_ch", out_ch, e4.ch);
                chk("dut4_out_data", out_data, e4.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_3 && out_ready_3) begin
            if (q3.size() == 0) begin
                n_checks++;
                $display("FAIL dut3_unexpected_word: got ch %0d data 0x%0h, expected none", out_ch_3, out_data_3);
            end else begin
                e3 = q3.pop_front();
                chk("dut3_out_ch", out_ch_3, e3.ch);
                chk("dut3_out_data", out_data_3, e3.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b1;
        mode_3 = 1'b1; sel_3 = 2'd0; in_valid_3 = 3'b000; in_data_3 = 24'h332211; out_ready_3 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("reset_in_ready", in_ready, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_out_ch", out_ch, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", in_ready, 4'b0001);

        // Round-robin fairness, back-to-back
        for (int i = 0; i < 8; i++) q4.push_back(mk(2'(i)));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_no_bubble", out_valid, 1'b1);
        end
        in_valid = 4'h0;
        step();
        chk("rr_drained_valid", out_valid, 1'b0);
        drain("rr_fair_queue", 4);

        // Fixed select
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
        #1;
        chk("fixed_ready", in_ready, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            q4.push_back(mk(2'd2));
            step();
            chk("fixed_ready_hold", in_ready, 4'b0100);
        end
        in_valid = 4'h0;
        step();
        drain("fixed_queue", 4);

        // Round-robin skipping and wrap
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = t4_valid[i];
            q4.push_back(mk(t4_ch[i]));
            #1;
            chk("rr_skip_ready", in_ready, t4_ready[i]);
            step();
        end
        in_valid = 4'hF;
        #1;
        chk("rr_ptr_after_wrap", in_ready, 4'b0100);
        in_valid = 4'h0;
        step();
        drain("rr_skip_queue", 4);

        // Back-pressure
        in_valid = 4'hF; out_ready = 1'b0;
        #1;
        chk("bp_first_ready", in_ready, 4'b0100);
        q4.push_back(mk(2'd2));
        step();
        repeat (3) begin
            chk("bp_ready_low", in_ready, 4'b0000);
            chk("bp_data_hold", out_data, 8'h33);
            chk("bp_ch_hold", out_ch, 2'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", in_ready, 4'b1000);
        q4.push_back(mk(2'd3));
        q4.push_back(mk(2'd0));
        q4.push_back(mk(2'd1));
        repeat (3) step();
        in_valid = 4'h0;
        step();
        drain("bp_queue", 4);

        // Asynchronous reset while a word is held
        in_valid = 4'hF; out_ready = 1'b0;
        step();
        chk("pre_reset_valid", out_valid, 1'b1);
        chk("pre_reset_ch", out_ch, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_data", out_data, 8'h00);
        chk("async_reset_ch", out_ch, 2'd0);
        chk("async_reset_ready", in_ready, 4'b0000);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_reset_ready", in_ready, 4'b0001);
        q4.push_back(mk(2'd0));
        step();
        in_valid = 4'h0;
        step();
        drain("post_reset_queue", 4);

        // Non-power-of-2 channel count
        mode_3 = 1'b0; sel_3 = 2'd3; in_valid_3 = 3'b111;
        #1;
        chk("np2_oob_ready", in_ready_3, 3'b000);
        repeat (3) begin
            step();
            chk("np2_oob_valid", out_valid_3, 1'b0);
            chk("np2_oob_ready_hold", in_ready_3, 3'b000);
        end
        mode_3 = 1'b1;
        #1;
        chk("np2_rr_ready", in_ready_3, 3'b001);
        q3.push_back(mk(2'd0));
        q3.push_back(mk(2'd1));
        q3.push_back(mk(2'd2));
        q3.push_back(mk(2'd0));
        repeat (4) step();
        in_valid_3 = 3'b000;
        step();
        drain("np2_rr_queue", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
